// File: rtl/alu_pkg.sv
// Shared opcode constants and writeback FSM state type for the ALU writeback stage.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  typedef enum logic [0:0] {
    WB_IDLE,
    WB_MUL_HI
  } wb_state_t;

endpackage

// File: rtl/alu_regfile.sv
// Register file: NUM_REGS x DATA_W, two combinational read ports, one synchronous write port.
module alu_regfile #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 8,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // No write bypass: a same-cycle read returns the pre-edge value.
  assign rd_data_a = regs_q[rd_addr_a];
  assign rd_data_b = regs_q[rd_addr_b];

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: commits results to the register file, holds sticky flags and
// splits a 16-bit multiply into low-byte and high-byte writes over two cycles.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 8,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_opcode,
  input  logic [ADDR_W-1:0]   in_rd,
  input  logic [DATA_W-1:0]   in_result,
  input  logic [2*DATA_W-1:0] in_mulresult,
  input  logic                in_carry,
  input  logic                in_zero,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  output logic [DATA_W-1:0]   rd_data_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [DATA_W-1:0]   rd_data_b,
  output logic                flag_carry,
  output logic                flag_zero,
  output logic                wb_valid,
  output logic [ADDR_W-1:0]   wb_addr,
  output logic [DATA_W-1:0]   wb_data,
  output logic [15:0]         wb_count
);

  wb_state_t         state_q, state_d;
  logic [DATA_W-1:0] hi_byte_q, hi_byte_d;
  logic [ADDR_W-1:0] hi_addr_q, hi_addr_d;
  logic              flag_carry_q, flag_carry_d;
  logic              flag_zero_q, flag_zero_d;
  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [15:0]       wb_count_q, wb_count_d;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  alu_regfile #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b)
  );

  always_comb begin
    state_d      = state_q;
    hi_byte_d    = hi_byte_q;
    hi_addr_d    = hi_addr_q;
    flag_carry_d = flag_carry_q;
    flag_zero_d  = flag_zero_q;
    wr_en        = 1'b0;
    wr_addr      = in_rd;
    wr_data      = in_result;

    case (state_q)
      WB_IDLE: begin
        if (in_valid) begin
          wr_en        = 1'b1;
          flag_carry_d = in_carry;
          flag_zero_d  = in_zero;
          if (in_opcode == OP_MUL) begin
            wr_data   = in_mulresult[DATA_W-1:0];
            hi_byte_d = in_mulresult[2*DATA_W-1:DATA_W];
            // Power-of-two register count makes the natural wrap give rd+1 mod NUM_REGS.
            hi_addr_d = in_rd + ADDR_W'(1);
            state_d   = WB_MUL_HI;
          end
        end
      end
      WB_MUL_HI: begin
        wr_en   = 1'b1;
        wr_addr = hi_addr_q;
        wr_data = hi_byte_q;
        state_d = WB_IDLE;
      end
    endcase

    wb_valid_d = wr_en;
    wb_addr_d  = wr_en ? wr_addr : wb_addr_q;
    wb_data_d  = wr_en ? wr_data : wb_data_q;
    wb_count_d = wr_en ? wb_count_q + 16'd1 : wb_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WB_IDLE;
      hi_byte_q    <= '0;
      hi_addr_q    <= '0;
      flag_carry_q <= 1'b0;
      flag_zero_q  <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      wb_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      hi_byte_q    <= hi_byte_d;
      hi_addr_q    <= hi_addr_d;
      flag_carry_q <= flag_carry_d;
      flag_zero_q  <= flag_zero_d;
      wb_valid_q   <= wb_valid_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      wb_count_q   <= wb_count_d;
    end
  end

  assign in_ready   = (state_q == WB_IDLE);
  assign flag_carry = flag_carry_q;
  assign flag_zero  = flag_zero_q;
  assign wb_valid   = wb_valid_q;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign wb_count   = wb_count_q;

endmodule
